alu_iter: RTL

Parametrised, handshaked successor to the 8-op combinational ALU.
- 16 ops on a WIDTH-bit datapath.
- Registered result and a Z/C/N/V flag register; C feeds the carry-chained ADC/SBC.
- Multi-bit shifts, and optionally multiply, execute iteratively under a small FSM.
- Sits between the register file/immediate decode and the writeback stage.

---
 rtl/alu_iter_if.sv | 40 ++++
 rtl/alu_iter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_if.sv
// alu_iter_if -- request/response bundle between operand decode, alu_iter
// and the writeback stage.
//
//   in_valid_i / in_ready_o  : request handshake (accept when both high)
//   func_i                   : 4-bit opcode
//   a_imm_i                  : immediate A operand (ADI only)
//   a_mem_i                  : memory A operand, zero-extended inside the ALU
//   b_i                      : B operand; low log2(WIDTH) bits are the shift amount
//   out_valid_o              : one-cycle completion pulse
//   result_o                 : registered result
//   fz_o/fc_o/fn_o/fv_o      : registered zero/carry(borrow)/negative/overflow flags
//
// Modport slave is the ALU side, master is the requester/consumer side.
interface alu_iter_if #(
   parameter int WIDTH   = 8,
   parameter int A_MEM_W = 4
);
   logic               in_valid_i;
   logic               in_ready_o;
   logic [3:0]         func_i;
   logic [WIDTH-1:0]   a_imm_i;
   logic [A_MEM_W-1:0] a_mem_i;
   logic [WIDTH-1:0]   b_i;
   logic               out_valid_o;
   logic [WIDTH-1:0]   result_o;
   logic               fz_o;
   logic               fc_o;
   logic               fn_o;
   logic               fv_o;

   modport slave (
      input  in_valid_i, func_i, a_imm_i, a_mem_i, b_i,
      output in_ready_o, out_valid_o, result_o, fz_o, fc_o, fn_o, fv_o
   );

   modport master (
      output in_valid_i, func_i, a_imm_i, a_mem_i, b_i,
      input  in_ready_o, out_valid_o, result_o, fz_o, fc_o, fn_o, fv_o
   );
endinterface

// File: rtl/alu_iter.sv
// alu_iter -- handshaked 16-op ALU with registered result and Z/C/N/V flags.
// Single-cycle ops complete one cycle after accept; SHL/SHR (and MUL when
// enabled) iterate one bit per cycle in the EXEC state.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : alu_iter_if.slave (handshake, opcode, operands, result, flags)
//
// Build option:
//   ALU_MUL_EN  defined   -> MUL runs as an iterative shift-add (latency WIDTH+1)
//               undefined -> MUL completes in one cycle with result 0, Z=1
module alu_iter #(
   parameter int WIDTH   = 8,
   parameter int A_MEM_W = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   alu_iter_if.slave  bus
);

   localparam int MSB  = WIDTH - 1;
   localparam int SH_W = $clog2(WIDTH);
`ifdef ALU_MUL_EN
   // MUL needs the counter to hold WIDTH itself.
   localparam int CNT_W = SH_W + 1;
`else
   localparam int CNT_W = SH_W;
`endif

   typedef enum logic [3:0] {
      OP_ADI  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND = 4'h3,
      OP_ORR  = 4'h4, OP_XOR  = 4'h5, OP_LSL1 = 4'h6, OP_LSR1 = 4'h7,
      OP_ADC  = 4'h8, OP_SBC  = 4'h9, OP_ASR1 = 4'hA, OP_ROL = 4'hB,
      OP_SHL  = 4'hC, OP_SHR  = 4'hD, OP_MUL  = 4'hE, OP_CMP = 4'hF
   } op_e;

   typedef enum logic {S_IDLE, S_EXEC} state_e;

   state_e             state_q, state_d;
   logic               pend_q, pend_d;        // single-cycle op waiting to retire
   op_e                func_q, func_d;
   logic [WIDTH-1:0]   work_q, work_d;        // captured A / shift work register
   logic [WIDTH-1:0]   b_q, b_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sbit_q, sbit_d;        // last bit shifted out
   logic [WIDTH-1:0]   result_q, result_d;
   logic               fz_q, fz_d, fc_q, fc_d, fn_q, fn_d, fv_q, fv_d;
   logic               out_valid_q, out_valid_d;
`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] prod_q, prod_d;        // {partial high, remaining multiplier}
   logic [WIDTH:0]     mul_sum;
`endif

   // Single-cycle datapath, evaluated on the captured operands.
   logic [WIDTH:0]          add_w, sub_w;
   logic                    add_v, sub_v;
   logic signed [WIDTH-1:0] b_s;
   logic [WIDTH-1:0]        sc_res;
   logic                    sc_c, sc_v, sc_wr;
   logic [WIDTH-1:0]        a_sel;

   always_comb begin
      add_w  = {1'b0, work_q} + {1'b0, b_q}
               + {{WIDTH{1'b0}}, (func_q == OP_ADC) & fc_q};
      // Bit WIDTH of the extended difference is the borrow.
      sub_w  = {1'b0, work_q} - {1'b0, b_q}
               - {{WIDTH{1'b0}}, (func_q == OP_SBC) & fc_q};
      add_v  = (work_q[MSB] == b_q[MSB]) && (add_w[MSB] != work_q[MSB]);
      sub_v  = (work_q[MSB] != b_q[MSB]) && (sub_w[MSB] != work_q[MSB]);
      b_s    = $signed(b_q);
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_wr  = 1'b1;
      case (func_q)
         OP_ADI, OP_ADD, OP_ADC: begin
            sc_res = add_w[MSB:0];
            sc_c   = add_w[WIDTH];
            sc_v   = add_v;
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            sc_res = sub_w[MSB:0];
            sc_c   = sub_w[WIDTH];
            sc_v   = sub_v;
            sc_wr  = (func_q != OP_CMP);
         end
         OP_AND:  sc_res = work_q & b_q;
         OP_ORR:  sc_res = work_q | b_q;
         OP_XOR:  sc_res = work_q ^ b_q;
         OP_LSL1: begin
            sc_res = {b_q[MSB-1:0], 1'b0};
            sc_c   = b_q[MSB];
         end
         OP_LSR1: begin
            sc_res = {1'b0, b_q[MSB:1]};
            sc_c   = b_q[0];
         end
         OP_ASR1: begin
            sc_res = $unsigned(b_s >>> 1);
            sc_c   = b_q[0];
         end
         OP_ROL: begin
            // {B,C} rotated left: C enters at bit 0, B's MSB becomes C.
            sc_res = {b_q[MSB-1:0], fc_q};
            sc_c   = b_q[MSB];
         end
         default: sc_res = '0;   // MUL without the multiplier option
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pend_d      = 1'b0;
      func_d      = func_q;
      work_d      = work_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      sbit_d      = sbit_q;
      result_d    = result_q;
      fz_d        = fz_q;
      fc_d        = fc_q;
      fn_d        = fn_q;
      fv_d        = fv_q;
      out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
      prod_d      = prod_q;
      mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, work_q};
`endif
      a_sel = (op_e'(bus.func_i) == OP_ADI) ? bus.a_imm_i : WIDTH'(bus.a_mem_i);

      // Retire the single-cycle op accepted on the previous edge.
      if (pend_q) begin
         if (sc_wr) begin
            result_d = sc_res;
         end
         fz_d        = (sc_res == '0);
         fc_d        = sc_c;
         fn_d        = sc_res[MSB];
         fv_d        = sc_v;
         out_valid_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid_i) begin
               func_d = op_e'(bus.func_i);
               work_d = a_sel;
               b_d    = bus.b_i;
               sbit_d = 1'b0;
               if (op_e'(bus.func_i) == OP_SHL || op_e'(bus.func_i) == OP_SHR) begin
                  state_d = S_EXEC;
                  cnt_d   = CNT_W'(bus.b_i[SH_W-1:0]);
`ifdef ALU_MUL_EN
               end else if (op_e'(bus.func_i) == OP_MUL) begin
                  state_d = S_EXEC;
                  cnt_d   = CNT_W'(WIDTH);
                  prod_d  = {{WIDTH{1'b0}}, bus.b_i};
`endif
               end else begin
                  pend_d = 1'b1;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
               case (func_q)
                  OP_SHL: begin
                     work_d = {work_q[MSB-1:0], 1'b0};
                     sbit_d = work_q[MSB];
                  end
                  OP_SHR: begin
                     work_d = {1'b0, work_q[MSB:1]};
                     sbit_d = work_q[0];
                  end
`ifdef ALU_MUL_EN
                  OP_MUL: begin
                     // Shift-add: add A into the high half when the current
                     // multiplier bit is set, then shift the whole pair right.
                     if (prod_q[0]) begin
                        prod_d = {mul_sum, prod_q[MSB:1]};
                     end else begin
                        prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
                     end
                  end
`endif
                  default: ;
               endcase
            end else begin
               state_d     = S_IDLE;
               out_valid_d = 1'b1;
               fv_d        = 1'b0;
`ifdef ALU_MUL_EN
               if (func_q == OP_MUL) begin
                  result_d = prod_q[MSB:0];
                  fc_d     = |prod_q[2*WIDTH-1:WIDTH];
                  fz_d     = (prod_q[MSB:0] == '0);
                  fn_d     = prod_q[MSB];
               end else
`endif
               begin
                  result_d = work_q;
                  fc_d     = sbit_q;
                  fz_d     = (work_q == '0);
                  fn_d     = work_q[MSB];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         fz_q        <= 1'b0;
         fc_q        <= 1'b0;
         fn_q        <= 1'b0;
         fv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         fz_q        <= fz_d;
         fc_q        <= fc_d;
         fn_q        <= fn_d;
         fv_q        <= fv_d;
      end
      func_q <= func_d;
      work_q <= work_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      sbit_q <= sbit_d;
`ifdef ALU_MUL_EN
      prod_q <= prod_d;
`endif
   end

   assign bus.in_ready_o  = (state_q == S_IDLE);
   assign bus.out_valid_o = out_valid_q;
   assign bus.result_o    = result_q;
   assign bus.fz_o        = fz_q;
   assign bus.fc_o        = fc_q;
   assign bus.fn_o        = fn_q;
   assign bus.fv_o        = fv_q;

endmodule
